// File: rtl/mips32_pkg.sv
// Shared definitions for the pipelined MIPS32 core and its memory read-back engine.
// Holds the default memory geometry, the HALT opcode, and the dump controller states.
package mips32_pkg;

    localparam int MEM_ADDR_W = 10;
    localparam int MEM_DATA_W = 32;

    localparam logic [5:0] HALT_OPCODE = 6'h3f;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_HALT = 2'd1,
        ST_READ      = 2'd2,
        ST_FINISH    = 2'd3
    } dump_state_e;

endpackage

// File: rtl/mips32_mem_dump_if.sv
// Control, memory read port, and result stream of the data-memory dump engine.
// master = dump engine side, slave = processor/memory/sink side.
interface mips32_mem_dump_if
    import mips32_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
);
    logic              halted;
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] end_addr;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              out_last;
    logic              busy;
    logic              done;

    modport master (
        input  halted, start, start_addr, end_addr, mem_rd_data, out_ready,
        output mem_rd_en, mem_rd_addr, out_valid, out_data, out_addr, out_last, busy, done
    );

    modport slave (
        output halted, start, start_addr, end_addr, mem_rd_data, out_ready,
        input  mem_rd_en, mem_rd_addr, out_valid, out_data, out_addr, out_last, busy, done
    );
endinterface

// File: rtl/mips32_skid_fifo.sv
// Two-entry FIFO with registered head; push and pop allowed in the same cycle.
// Latency: push visible at head one cycle later; backpressure: push ignored when full unless popping.
module mips32_skid_fifo #(
    parameter int W = 43
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic [1:0]   count,
    output logic         empty,
    output logic         full
);
    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         pop_ok, push_ok;

    assign empty    = (count_q == 2'd0);
    assign full     = (count_q == 2'd2);
    assign count    = count_q;
    assign head_dat = mem_q[rd_ptr_q];
    assign pop_ok   = pop && !empty;
    assign push_ok  = push && (!full || pop_ok);

    always_comb begin
        mem_d[0] = mem_q[0];
        mem_d[1] = mem_q[1];
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop_ok) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end

    // Storage is cleared too so the head reads as zero straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mips32_mem_dump.sv
// After HALT, reads a word-address range from data memory and streams (addr, data, last) words.
// Latency: first word valid two edges after start; backpressure: at most 2 words buffered, reads stall.
module mips32_mem_dump
    import mips32_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    mips32_mem_dump_if.master bus
);
    typedef struct packed {
        logic              last;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] dat;
    } entry_t;

    dump_state_e       state_q, state_d;
    logic [ADDR_W-1:0] end_q, end_d;
    logic [ADDR_W:0]   addr_q, addr_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflight_addr_q, inflight_addr_d;

    entry_t            push_ent;
    entry_t            head_ent;
    logic [1:0]        fifo_count;
    logic              fifo_empty;
    logic              fifo_full;
    logic              pop;
    logic              rd_en;
    logic [1:0]        occ;
    logic              issue_ok;
    logic              range_left;

    assign pop        = !fifo_empty && bus.out_ready;
    assign occ        = fifo_count + {1'b0, inflight_q};
    // A slot being popped this cycle can be reused by the next read, but never
    // while both entries are still physically held.
    assign issue_ok   = (occ < 2'd2) || (pop && !fifo_full);
    // Extra counter bit lets end_addr = all-ones terminate instead of wrapping.
    assign range_left = (addr_q <= {1'b0, end_q});
    assign rd_en      = (state_q == ST_READ) && range_left && issue_ok;

    assign push_ent.last = (inflight_addr_q == end_q);
    assign push_ent.addr = inflight_addr_q;
    assign push_ent.dat  = bus.mem_rd_data;

    mips32_skid_fifo #(
        .W($bits(entry_t))
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (inflight_q),
        .push_dat (push_ent),
        .pop      (pop),
        .head_dat (head_ent),
        .count    (fifo_count),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    assign bus.mem_rd_en   = rd_en;
    assign bus.mem_rd_addr = addr_q[ADDR_W-1:0];
    assign bus.out_valid   = !fifo_empty;
    assign bus.out_data    = head_ent.dat;
    assign bus.out_addr    = head_ent.addr;
    assign bus.out_last    = head_ent.last;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.done        = (state_q == ST_FINISH);

    always_comb begin
        state_d         = state_q;
        end_d           = end_q;
        addr_d          = addr_q;
        inflight_d      = rd_en;
        inflight_addr_d = addr_q[ADDR_W-1:0];
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    end_d  = bus.end_addr;
                    addr_d = {1'b0, bus.start_addr};
                    if (bus.end_addr < bus.start_addr) begin
                        state_d = ST_FINISH;
                    end else if (bus.halted) begin
                        state_d = ST_READ;
                    end else begin
                        state_d = ST_WAIT_HALT;
                    end
                end
            end
            ST_WAIT_HALT: begin
                if (bus.halted) begin
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                if (rd_en) begin
                    addr_d = addr_q + 1'b1;
                end
                if (pop && head_ent.last) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            end_q           <= '0;
            addr_q          <= '0;
            inflight_q      <= 1'b0;
            inflight_addr_q <= '0;
        end else begin
            state_q         <= state_d;
            end_q           <= end_d;
            addr_q          <= addr_d;
            inflight_q      <= inflight_d;
            inflight_addr_q <= inflight_addr_d;
        end
    end

endmodule

// File: tb/tb_mips32_mem_dump.sv
// Directed bench for mips32_mem_dump: memory model, negedge stream monitor, one task per scenario.
module tb_mips32_mem_dump;
    import mips32_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    mips32_mem_dump_if bus ();

    mips32_mem_dump dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    logic [MEM_DATA_W-1:0] mem [0:1023];

    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_rd_addr];
    end

    int checks = 0;
    int errors = 0;

    int ncyc = 0;
    int start_cyc, first_rd_cyc, first_valid_cyc, done_cyc;
    int done_cnt, rd_cnt, full_issue, stab_err, valid_err;
    int buf_cnt;
    bit en_d1, en_d2, hs_d1, stalled_prev, hs;
    logic [MEM_DATA_W-1:0] p_data;
    logic [MEM_ADDR_W-1:0] p_addr;
    logic                  p_last;
    int q_addr[$];
    int q_data[$];
    int q_last[$];
    int q_cyc[$];

    always @(negedge clk) begin
        ncyc++;
        if (rst) begin
            buf_cnt = 0; en_d1 = 0; en_d2 = 0; hs_d1 = 0; stalled_prev = 0;
        end else begin
            buf_cnt = buf_cnt + int'(en_d2) - int'(hs_d1);
            if (bus.out_valid !== (buf_cnt > 0)) valid_err++;
            if (bus.start) start_cyc = ncyc;
            if (bus.mem_rd_en) begin
                rd_cnt++;
                if (first_rd_cyc < 0) first_rd_cyc = ncyc;
                if (buf_cnt >= 2) full_issue++;
            end
            if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = ncyc;
            if (bus.done) begin
                done_cnt++;
                done_cyc = ncyc;
            end
            if (stalled_prev && (!bus.out_valid || bus.out_data !== p_data ||
                                 bus.out_addr !== p_addr || bus.out_last !== p_last))
                stab_err++;
            hs = bus.out_valid && bus.out_ready;
            if (hs) begin
                q_addr.push_back(int'(bus.out_addr));
                q_data.push_back(int'(bus.out_data));
                q_last.push_back(int'(bus.out_last));
                q_cyc.push_back(ncyc);
            end
            stalled_prev = bus.out_valid && !bus.out_ready;
            p_data = bus.out_data;
            p_addr = bus.out_addr;
            p_last = bus.out_last;
            en_d2  = en_d1;
            en_d1  = bus.mem_rd_en;
            hs_d1  = hs;
        end
    end

    task automatic clear_mon;
        start_cyc = -1; first_rd_cyc = -1; first_valid_cyc = -1; done_cyc = -1;
        done_cnt = 0; rd_cnt = 0; full_issue = 0; stab_err = 0; valid_err = 0;
        q_addr.delete(); q_data.delete(); q_last.delete(); q_cyc.delete();
    endtask

    task automatic do_start(input logic [MEM_ADDR_W-1:0] s, input logic [MEM_ADDR_W-1:0] e);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.start_addr = s; bus.end_addr = e;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (done_cnt > 0) begin
                timed_out = 1'b0;
                break;
            end
        end
        #1;
    endtask

    task automatic test_reset;
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.mem_rd_en, bus.mem_rd_addr, bus.out_valid, bus.out_data, bus.out_addr,
             bus.out_last, bus.busy, bus.done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got en=%b addr=%0d vld=%b dat=%0h oaddr=%0d last=%b busy=%b done=%b, want all 0",
                     bus.mem_rd_en, bus.mem_rd_addr, bus.out_valid, bus.out_data, bus.out_addr,
                     bus.out_last, bus.busy, bus.done);
        end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_basic;
        bit to;
        mem[120] = 32'd85; mem[121] = 32'd130;
        bus.halted = 1'b1; bus.out_ready = 1'b1;
        clear_mon();
        do_start(10'd120, 10'd121);
        wait_done(50, to);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL basic_timeout: done not seen"); end
        checks++; if (q_addr.size() !== 2) begin errors++; $display("FAIL basic_count: got %0d words, want 2", q_addr.size()); end
        checks++; if ({q_addr[0], q_data[0], q_last[0]} !== {32'd120, 32'd85, 32'd0}) begin
            errors++; $display("FAIL basic_w0: got (%0d,%0d,%0d) want (120,85,0)", q_addr[0], q_data[0], q_last[0]); end
        checks++; if ({q_addr[1], q_data[1], q_last[1]} !== {32'd121, 32'd130, 32'd1}) begin
            errors++; $display("FAIL basic_w1: got (%0d,%0d,%0d) want (121,130,1)", q_addr[1], q_data[1], q_last[1]); end
        checks++; if (first_rd_cyc !== start_cyc + 1) begin
            errors++; $display("FAIL basic_rd_lat: got %0d want %0d", first_rd_cyc - start_cyc, 1); end
        checks++; if (first_valid_cyc !== start_cyc + 3) begin
            errors++; $display("FAIL basic_valid_lat: got %0d cycles want 3", first_valid_cyc - start_cyc); end
        checks++; if (q_cyc[1] !== q_cyc[0] + 1) begin
            errors++; $display("FAIL basic_no_bubble: gap %0d want 1", q_cyc[1] - q_cyc[0]); end
        checks++; if (done_cyc !== q_cyc[1] + 1 || done_cnt !== 1) begin
            errors++; $display("FAIL basic_done: at +%0d count %0d, want +1 count 1", done_cyc - q_cyc[1], done_cnt); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_wait_halt;
        bit to;
        bus.halted = 1'b0;
        clear_mon();
        do_start(10'd120, 10'd121);
        repeat (10) @(posedge clk);
        #1;
        checks++; if (rd_cnt !== 0) begin errors++; $display("FAIL wait_no_reads: got %0d reads want 0", rd_cnt); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL wait_busy: got %b want 1", bus.busy); end
        bus.halted = 1'b1;
        wait_done(50, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL wait_timeout: done not seen"); end
        checks++; if (q_addr.size() !== 2 || {q_addr[0], q_data[0], q_last[0], q_addr[1], q_data[1], q_last[1]} !==
                      {32'd120, 32'd85, 32'd0, 32'd121, 32'd130, 32'd1}) begin
            errors++; $display("FAIL wait_stream: got %0d words (%0d,%0d,%0d)(%0d,%0d,%0d) want (120,85,0)(121,130,1)",
                               q_addr.size(), q_addr[0], q_data[0], q_last[0], q_addr[1], q_data[1], q_last[1]); end
    endtask

    task automatic test_backpressure;
        bit to;
        for (int k = 0; k < 8; k++) mem[k] = 32'(k + 100);
        bus.out_ready = 1'b0; bus.halted = 1'b1;
        clear_mon();
        do_start(10'd0, 10'd7);
        repeat (6) @(posedge clk);
        #1;
        checks++; if (rd_cnt !== 2 || bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_hold: got %0d reads vld=%b want 2 reads vld=1", rd_cnt, bus.out_valid); end
        bus.halted = 1'b0;
        to = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            bus.out_ready = ~bus.out_ready;
            if (done_cnt > 0) begin
                to = 1'b0;
                break;
            end
        end
        bus.out_ready = 1'b1; bus.halted = 1'b1;
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL bp_timeout: done not seen"); end
        checks++; if (q_addr.size() !== 8) begin errors++; $display("FAIL bp_count: got %0d words want 8", q_addr.size()); end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if ({q_addr[k], q_data[k], q_last[k]} !== {32'(k), 32'(k + 100), 32'(k == 7)}) begin
                errors++; $display("FAIL bp_word%0d: got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
                                   k, q_addr[k], q_data[k], q_last[k], k, k + 100, (k == 7)); end
        end
        checks++; if (stab_err !== 0) begin errors++; $display("FAIL bp_stable: got %0d unstable stalls want 0", stab_err); end
        checks++; if (full_issue !== 0) begin errors++; $display("FAIL bp_read_when_full: got %0d want 0", full_issue); end
        checks++; if (valid_err !== 0) begin errors++; $display("FAIL bp_valid_occupancy: got %0d want 0", valid_err); end
        checks++; if (rd_cnt !== 8 || done_cnt !== 1) begin
            errors++; $display("FAIL bp_totals: got %0d reads %0d done want 8 reads 1 done", rd_cnt, done_cnt); end
    endtask

    task automatic test_top_boundary;
        bit to;
        mem[1023] = 32'hdeadbeef; mem[0] = 32'h11111111;
        clear_mon();
        do_start(10'd1023, 10'd1023);
        wait_done(50, to);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL top_timeout: done not seen"); end
        checks++; if (q_addr.size() !== 1 || {q_addr[0], q_data[0], q_last[0]} !== {32'd1023, 32'hdeadbeef, 32'd1}) begin
            errors++; $display("FAIL top_word: got %0d words (%0d,%0h,%0d) want 1 (1023,deadbeef,1)",
                               q_addr.size(), q_addr[0], q_data[0], q_last[0]); end
        checks++; if (rd_cnt !== 1) begin errors++; $display("FAIL top_no_wrap: got %0d reads want 1", rd_cnt); end
    endtask

    task automatic test_empty_range;
        bit to;
        clear_mon();
        do_start(10'd5, 10'd4);
        wait_done(20, to);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL empty_timeout: done not seen"); end
        checks++; if (rd_cnt !== 0 || first_valid_cyc !== -1) begin
            errors++; $display("FAIL empty_activity: got %0d reads valid_at=%0d want 0 reads, no valid", rd_cnt, first_valid_cyc); end
        checks++; if (done_cyc !== start_cyc + 1 || done_cnt !== 1) begin
            errors++; $display("FAIL empty_done: at +%0d count %0d want +1 count 1", done_cyc - start_cyc, done_cnt); end
    endtask

    task automatic test_reset_mid;
        bit to;
        for (int k = 0; k < 10; k++) mem[k] = 32'(k * 3 + 7);
        bus.out_ready = 1'b1;
        clear_mon();
        do_start(10'd0, 10'd9);
        to = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            if (q_addr.size() >= 3) begin
                to = 1'b0;
                break;
            end
        end
        #1 rst = 1'b1;
        #1;
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL rstmid_timeout: third word not seen"); end
        checks++;
        if ({bus.mem_rd_en, bus.mem_rd_addr, bus.out_valid, bus.out_data, bus.out_addr,
             bus.out_last, bus.busy, bus.done} !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs: got en=%b addr=%0d vld=%b dat=%0h oaddr=%0d last=%b busy=%b done=%b, want all 0",
                     bus.mem_rd_en, bus.mem_rd_addr, bus.out_valid, bus.out_data, bus.out_addr,
                     bus.out_last, bus.busy, bus.done);
        end
        checks++; if (done_cnt !== 0) begin errors++; $display("FAIL rstmid_no_done: got %0d want 0", done_cnt); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mem[0] = 32'h0a0a; mem[1] = 32'hb0b0;
        clear_mon();
        do_start(10'd0, 10'd1);
        wait_done(50, to);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL rstmid_restart_timeout: done not seen"); end
        checks++; if (q_addr.size() !== 2 || {q_addr[0], q_data[0], q_last[0], q_addr[1], q_data[1], q_last[1]} !==
                      {32'd0, 32'h0a0a, 32'd0, 32'd1, 32'hb0b0, 32'd1}) begin
            errors++; $display("FAIL rstmid_restart_stream: got %0d words (%0d,%0h,%0d)(%0d,%0h,%0d) want (0,a0a,0)(1,b0b0,1)",
                               q_addr.size(), q_addr[0], q_data[0], q_last[0], q_addr[1], q_data[1], q_last[1]); end
    endtask

    task automatic test_start_ignored;
        bit to;
        bus.out_ready = 1'b1; bus.halted = 1'b1;
        clear_mon();
        do_start(10'd120, 10'd121);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.start_addr = 10'd5; bus.end_addr = 10'd6;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(50, to);
        repeat (5) @(posedge clk);
        #1;
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL busy_start_timeout: done not seen"); end
        checks++; if (q_addr.size() !== 2 || q_addr[0] !== 120 || q_addr[1] !== 121) begin
            errors++; $display("FAIL busy_start_range: got %0d words addr %0d,%0d want 2 words 120,121",
                               q_addr.size(), q_addr[0], q_addr[1]); end
        checks++; if (rd_cnt !== 2 || done_cnt !== 1 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL busy_start_after: got %0d reads %0d done busy=%b want 2 reads 1 done busy=0",
                               rd_cnt, done_cnt, bus.busy); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        bus.halted = 1'b0; bus.start = 1'b0; bus.start_addr = '0; bus.end_addr = '0;
        bus.out_ready = 1'b0; bus.mem_rd_data = '0;
        clear_mon();
        test_reset();
        test_basic();
        test_wait_halt();
        test_backpressure();
        test_top_boundary();
        test_empty_range();
        test_reset_mid();
        test_start_ignored();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
